// File: rtl/instr_issue.sv
// instr_issue: sequences a 16-word program memory and hands each instruction to
// an external executor one at a time.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   ld_en/ld_addr/ld_data  program-memory write port (ignored while busy)
//   start              single-cycle run request (ignored while busy)
//   err                executor error flag, looked at only in CHECK
//   op/a/b             issued instruction fields (hold last issued value)
//   issue_valid        op/a/b valid this cycle
//   busy               high in FETCH, ISSUE, CHECK
//   done/fault         run outcome, held until next accepted start or rst
//   fault_code         01 executor error, 10 malformed word, 00 none
//   fault_pc           address of the faulting word
//   issue_count        instructions issued in the current run (0-16)
module instr_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_en,
    input  logic [3:0]  ld_addr,
    input  logic [31:0] ld_data,
    input  logic        start,
    input  logic        err,
    output logic [3:0]  op,
    output logic [3:0]  a,
    output logic [23:0] b,
    output logic        issue_valid,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [3:0]  fault_pc,
    output logic [4:0]  issue_count
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StFetch = 3'd1;
    localparam logic [2:0] StIssue = 3'd2;
    localparam logic [2:0] StCheck = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;
    localparam logic [2:0] StFault = 3'd5;

    localparam logic [31:0] HaltWord = 32'hF000_0000;

    logic [31:0] mem_q [16];

    logic [2:0]  state_q, state_d;
    logic [3:0]  pc_q, pc_d;
    logic [3:0]  op_q, op_d;
    logic [3:0]  a_q, a_d;
    logic [23:0] b_q, b_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic [1:0]  fault_code_q, fault_code_d;
    logic [3:0]  fault_pc_q, fault_pc_d;
    logic [4:0]  issue_count_q, issue_count_d;

    logic [31:0] fetch_w;
    logic [3:0]  f_op;
    logic [3:0]  f_a;
    logic [23:0] f_b;
    logic        f_halt;
    logic        f_malformed;

    assign fetch_w = mem_q[pc_q];
    assign f_op    = fetch_w[31:28];
    assign f_a     = fetch_w[27:24];
    assign f_b     = fetch_w[23:0];
    assign f_halt  = (f_op == 4'hF);
    // Opcodes 9-14 are undefined; a[3] selects a mode whose b[11:3] must be zero.
    assign f_malformed = ((f_op >= 4'd9) && (f_op <= 4'd14)) ||
                         (f_a[3] && (f_b[11:3] != 9'd0));

    assign issue_valid = (state_q == StIssue);
    assign busy        = (state_q == StFetch) || (state_q == StIssue) ||
                         (state_q == StCheck);
    assign op          = op_q;
    assign a           = a_q;
    assign b           = b_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;
    assign fault_pc    = fault_pc_q;
    assign issue_count = issue_count_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        done_d        = done_q;
        fault_d       = fault_q;
        fault_code_d  = fault_code_q;
        fault_pc_d    = fault_pc_q;
        issue_count_d = issue_count_q;
        case (state_q)
            StIdle, StDone, StFault: begin
                if (start) begin
                    state_d       = StFetch;
                    pc_d          = 4'd0;
                    done_d        = 1'b0;
                    fault_d       = 1'b0;
                    fault_code_d  = 2'b00;
                    fault_pc_d    = 4'd0;
                    issue_count_d = 5'd0;
                end
            end
            StFetch: begin
                if (f_halt) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else if (f_malformed) begin
                    state_d      = StFault;
                    fault_d      = 1'b1;
                    fault_code_d = 2'b10;
                    fault_pc_d   = pc_q;
                end else begin
                    state_d = StIssue;
                    op_d    = f_op;
                    a_d     = f_a;
                    b_d     = f_b;
                end
            end
            StIssue: begin
                state_d       = StCheck;
                issue_count_d = issue_count_q + 5'd1;
            end
            StCheck: begin
                if (err) begin
                    state_d      = StFault;
                    fault_d      = 1'b1;
                    fault_code_d = 2'b01;
                    fault_pc_d   = pc_q;
                end else if (pc_q == 4'd15) begin
                    // Last word executed: finish rather than wrapping the pc.
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    state_d = StFetch;
                    pc_d    = pc_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            pc_q          <= 4'd0;
            op_q          <= 4'd0;
            a_q           <= 4'd0;
            b_q           <= 24'd0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            fault_code_q  <= 2'b00;
            fault_pc_q    <= 4'd0;
            issue_count_q <= 5'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
            fault_pc_q    <= fault_pc_d;
            issue_count_q <= issue_count_d;
        end
    end

    // Reset refills the program with HALT so a bare start finishes immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= HaltWord;
            end
        end else if (ld_en && !busy) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

endmodule

// File: tb/tb_instr_issue.sv
module tb_instr_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = 4'd0;
    logic [31:0] ld_data = 32'd0;
    logic        start = 1'b0;
    logic        err = 1'b0;
    logic [3:0]  op;
    logic [3:0]  a;
    logic [23:0] b;
    logic        issue_valid;
    logic        busy;
    logic        done;
    logic        fault;
    logic [1:0]  fault_code;
    logic [3:0]  fault_pc;
    logic [4:0]  issue_count;

    instr_issue dut (
        .clk        (clk),
        .rst        (rst),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .start      (start),
        .err        (err),
        .op         (op),
        .a          (a),
        .b          (b),
        .issue_valid(issue_valid),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_pc   (fault_pc),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: program image, per-address executor error plan, outcome.
    logic [31:0] mem_m [16];
    bit          errp [16];
    logic [31:0] exp_iss [$];
    int          exp_end_c;
    bit          exp_done;
    bit          exp_fault;
    logic [1:0]  exp_code;
    logic [3:0]  exp_pc;
    logic [31:0] last_w;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Walk the program as the executor would see it. Cycle offsets are counted
    // from the edge that accepts start: word p is fetched in cycle 1+3p.
    task automatic model();
        logic [31:0] w;
        exp_iss.delete();
        exp_done  = 1'b0;
        exp_fault = 1'b0;
        exp_code  = 2'b00;
        exp_pc    = 4'd0;
        exp_end_c = 4 + 3 * 15;
        for (int p = 0; p < 16; p++) begin
            w = mem_m[p];
            if (w[31:28] == 4'hF) begin
                exp_done  = 1'b1;
                exp_end_c = 2 + 3 * p;
                return;
            end
            if ((w[31:28] >= 4'd9) || (w[27] && (w[11:3] != 9'd0))) begin
                exp_fault = 1'b1;
                exp_code  = 2'b10;
                exp_pc    = 4'(p);
                exp_end_c = 2 + 3 * p;
                return;
            end
            exp_iss.push_back(w);
            if (errp[p]) begin
                exp_fault = 1'b1;
                exp_code  = 2'b01;
                exp_pc    = 4'(p);
                exp_end_c = 4 + 3 * p;
                return;
            end
        end
        exp_done = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_op_a_b"}, {op, a, b}, 32'd0);
        chk({tag, "_issue_valid"}, issue_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_fault_code"}, fault_code, 0);
        chk({tag, "_fault_pc"}, fault_pc, 0);
        chk({tag, "_issue_count"}, issue_count, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        start   = 1'b1;
        ld_en   = 1'b1;
        ld_addr = 4'($urandom);
        ld_data = 32'h1000_0000;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        ld_en = 1'b0;
        for (int i = 0; i < 16; i++) mem_m[i] = 32'hF000_0000;
        last_w = 32'd0;
        check_zero("reset");
    endtask

    task automatic load_word(input int addr, input logic [31:0] data);
        @(negedge clk);
        start   = 1'b0;
        ld_en   = 1'b1;
        ld_addr = 4'(addr);
        ld_data = data;
        mem_m[addr] = data;
    endtask

    task automatic clear_errp();
        for (int i = 0; i < 16; i++) errp[i] = 1'b0;
    endtask

    task automatic run_prog(input int abort_c);
        bit exp_iv;
        int cnt;
        model();
        @(negedge clk);
        ld_en = 1'b0;
        start = 1'b1;
        err   = 1'($urandom);
        for (int c = 1; c <= exp_end_c; c++) begin
            @(negedge clk);
            start  = 1'b0;
            ld_en  = 1'b0;
            exp_iv = (c < exp_end_c) && (c >= 2) && (((c - 2) % 3) == 0);
            if (exp_iv) last_w = exp_iss[(c - 2) / 3];
            chk("issue_valid", issue_valid, exp_iv);
            chk("op_a_b", {op, a, b}, last_w);
            cnt = (c >= 3) ? ((c - 3) / 3 + 1) : 0;
            if (cnt > exp_iss.size()) cnt = exp_iss.size();
            chk("issue_count", issue_count, cnt);
            if (c < exp_end_c) begin
                chk("busy_run", busy, 1);
                chk("done_run", done, 0);
                chk("fault_run", fault, 0);
                chk("fault_code_run", fault_code, 0);
            end else begin
                chk("busy_end", busy, 0);
                chk("done_end", done, exp_done);
                chk("fault_end", fault, exp_fault);
                chk("fault_code_end", fault_code, exp_code);
                chk("fault_pc_end", fault_pc, exp_pc);
            end
            if (c == abort_c) begin
                rst   = 1'b1;
                start = 1'b1;
                @(negedge clk);
                rst   = 1'b0;
                start = 1'b0;
                for (int i = 0; i < 16; i++) mem_m[i] = 32'hF000_0000;
                last_w = 32'd0;
                check_zero("abort");
                for (int j = 0; j < 6; j++) begin
                    @(negedge clk);
                    chk("abort_no_issue", issue_valid, 0);
                    chk("abort_idle", busy, 0);
                end
                return;
            end
            if (c < exp_end_c) begin
                // err matters only in CHECK cycles (3+3p); elsewhere it is noise.
                if ((c >= 3) && (((c - 3) % 3) == 0)) err = errp[(c - 3) / 3];
                else err = 1'($urandom);
                ld_en   = ($urandom_range(0, 3) == 0);
                ld_addr = 4'($urandom);
                ld_data = $urandom;
                start   = ($urandom_range(0, 3) == 0);
            end
        end
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            err = 1'($urandom);
            chk("hold_done", done, exp_done);
            chk("hold_fault", fault, exp_fault);
            chk("hold_busy", busy, 0);
            chk("hold_issue_valid", issue_valid, 0);
            chk("hold_count", issue_count, exp_iss.size());
        end
    endtask

    function automatic logic [31:0] rand_word();
        int r;
        logic [3:0] o;
        r = $urandom_range(0, 19);
        o = 4'($urandom_range(0, 8));
        if (r == 15 || r == 16) return 32'hF000_0000;
        if (r == 17 || r == 18) return {4'($urandom_range(9, 14)), 28'($urandom)};
        if (r == 19) return {o, 1'b1, 3'($urandom), 12'($urandom), 9'($urandom_range(1, 511)), 3'($urandom)};
        return {o, 28'($urandom)};
    endfunction

    initial begin
        last_w = 32'd0;
        clear_errp();
        do_reset();

        // Bare start after reset: program is all HALT.
        run_prog(0);
        chk("bare_count", issue_count, 0);
        chk("bare_done", done, 1);

        // Two issues then HALT.
        load_word(0, 32'h5000_0007);
        load_word(1, 32'h0000_0003);
        load_word(2, 32'hF000_0000);
        run_prog(0);
        chk("two_count", issue_count, 2);
        chk("two_last_b", b, 24'd3);

        // Executor error on the first instruction.
        load_word(0, 32'h0800_0001);
        errp[0] = 1'b1;
        run_prog(0);
        chk("err_code", fault_code, 2'b01);
        clear_errp();

        // Malformed word at address 1, then a malformed mode word alone.
        load_word(0, 32'h5000_0007);
        load_word(1, 32'h9000_0000);
        run_prog(0);
        chk("mal1_pc", fault_pc, 4'd1);
        load_word(0, 32'h0800_0008);
        run_prog(0);
        chk("mal0_count", issue_count, 0);

        // Full program of 16 valid words, with ld_en noise during the run.
        for (int i = 0; i < 16; i++) load_word(i, {4'h0, 4'h1, 24'($urandom)});
        run_prog(0);
        chk("full_count", issue_count, 16);
        run_prog(0);

        // Randomized programs and error plans.
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 4) == 0) do_reset();
            for (int i = 0; i < 16; i++) begin
                load_word(i, rand_word());
                errp[i] = ($urandom_range(0, 11) == 0);
            end
            run_prog(0);
        end

        // Reset in the ISSUE cycle of the fourth instruction.
        clear_errp();
        for (int i = 0; i < 16; i++) load_word(i, {4'($urandom_range(0, 8)), 4'h2, 24'($urandom)});
        run_prog(2 + 3 * 3);
        run_prog(0);
        chk("post_abort_halt", done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
